// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundles the signals exchanged between a five-stage pipeline datapath and its
// hazard controller (pipe_hazard_ctrl).
//
//   master : the pipeline datapath. It drives the register addresses and flags
//            of the FD/DX/XM/MW registers, the branch outcome and the
//            data-memory handshake. It receives the stage enables, the bubble
//            flushes, the forwarding selects and the status/counter outputs.
//   slave  : the hazard controller. It has the opposite directions.
//
// Parameter CNT_W sets the width of the two performance counters. It must
// match the CNT_W of the controller that the interface is connected to.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Decode stage (FD register)
    logic [4:0]       d_rs1_i;
    logic [4:0]       d_rs2_i;
    logic             d_use_rs1_i;
    logic             d_use_rs2_i;
    // Execute stage (DX register)
    logic [4:0]       x_rs1_i;
    logic [4:0]       x_rs2_i;
    logic [4:0]       x_rd_i;
    logic             x_memread_i;
    // Memory stage (XM register)
    logic [4:0]       m_rd_i;
    logic             m_regwrite_i;
    logic             m_branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    // Writeback stage (MW register)
    logic [4:0]       w_rd_i;
    logic             w_regwrite_i;
    // Stage controls
    logic             pc_en_o;
    logic             fd_en_o;
    logic             dx_en_o;
    logic             xm_en_o;
    logic             fd_flush_o;
    logic             dx_flush_o;
    logic             xm_flush_o;
    logic             mw_flush_o;
    // Forwarding selects
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    // Status
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    modport master (
        output d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i,
        output x_rs1_i, x_rs2_i, x_rd_i, x_memread_i,
        output m_rd_i, m_regwrite_i, m_branch_taken_i, dmem_req_i, dmem_ack_i,
        output w_rd_i, w_regwrite_i,
        input  pc_en_o, fd_en_o, dx_en_o, xm_en_o,
        input  fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o,
        input  fwd_a_o, fwd_b_o,
        input  state_o, stall_cnt_o, flush_cnt_o, err_o
    );

    modport slave (
        input  d_rs1_i, d_rs2_i, d_use_rs1_i, d_use_rs2_i,
        input  x_rs1_i, x_rs2_i, x_rd_i, x_memread_i,
        input  m_rd_i, m_regwrite_i, m_branch_taken_i, dmem_req_i, dmem_ack_i,
        input  w_rd_i, w_regwrite_i,
        output pc_en_o, fd_en_o, dx_en_o, xm_en_o,
        output fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o,
        output fwd_a_o, fwd_b_o,
        output state_o, stall_cnt_o, flush_cnt_o, err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a five-stage pipeline (F, D, X, M, W). It produces:
//   * stage register enables and bubble flushes. These are combinational from
//     the current state and the inputs, so they act in the same cycle.
//   * ALU operand forwarding selects for the X stage.
//   * a small FSM that tracks data-memory waits (RUN / MEM_WAIT / ERROR).
//   * saturating counters for stall cycles and branch flushes.
//
// Ports:
//   clk_i    : clock. All state changes on its rising edge.
//   reset_i  : asynchronous reset, active low.
//   bus      : pipe_hazard_ctrl_if.slave. It carries the pipeline register
//              fields, the branch/memory handshake, and all control and
//              status outputs.
//
// Control priority while the pipeline is allowed to run:
//   data-memory freeze  >  taken-branch flush  >  load-use stall
//
// Forwarding select encoding:
//   2'b00 = register file, 2'b10 = XM result, 2'b01 = MW writeback.
//
// While reset_i is low the control outputs are forced to their idle values:
// all enables 1, all flushes 0, forwarding 00. This keeps the datapath
// loading the values its own reset establishes.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERROR    = 2'b10;

    // The wait counter must be able to hold ACK_TIMEOUT itself.
    localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

    // Increment that stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Forwarding select for one X-stage source register. The nearer producer
    // (XM) wins over MW. x0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end
        if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WC_W-1:0]  wait_cnt;
    logic [WC_W-1:0]  wait_nxt;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic             mem_miss;
    logic             load_use;
    logic             freeze;
    logic             release_ok;
    logic             do_branch;

    logic             pc_en;
    logic             fd_en;
    logic             dx_en;
    logic             xm_en;
    logic             fd_fl;
    logic             dx_fl;
    logic             xm_fl;
    logic             mw_fl;

    // -------------------------------------------------------------------------
    // Next state and stage controls (combinational)
    // -------------------------------------------------------------------------
    always_comb begin
        mem_miss = bus.dmem_req_i && !bus.dmem_ack_i;

        // A load in X whose destination a source of the D instruction needs.
        // The value is not available until after M, so D must wait one cycle.
        load_use = bus.x_memread_i && (bus.x_rd_i != 5'd0) &&
                   ((bus.d_use_rs1_i && (bus.x_rd_i == bus.d_rs1_i)) ||
                    (bus.d_use_rs2_i && (bus.x_rd_i == bus.d_rs2_i)));

        freeze     = 1'b0;
        release_ok = 1'b0;
        state_nxt  = state;
        wait_nxt   = wait_cnt;

        // freeze     : the whole pipeline holds and MW takes a bubble.
        // release_ok : the normal branch/load-use rules apply this cycle.
        //              This includes the cycle in which a pending ack arrives.
        case (state)
            ST_RUN: begin
                if (mem_miss) begin
                    freeze    = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = '0;
                end else begin
                    // A request that is acked in the same cycle costs nothing.
                    release_ok = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    release_ok = 1'b1;
                    state_nxt  = ST_RUN;
                    wait_nxt   = '0;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + WC_W'(1);
                    if (wait_nxt == WC_W'(ACK_TIMEOUT)) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                // Only reset leaves this state. Ack and branch are ignored.
                freeze = 1'b1;
            end
            default: begin
                // The unused encoding falls back to RUN.
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase

        do_branch = release_ok && bus.m_branch_taken_i;

        pc_en = 1'b1;
        fd_en = 1'b1;
        dx_en = 1'b1;
        xm_en = 1'b1;
        fd_fl = 1'b0;
        dx_fl = 1'b0;
        xm_fl = 1'b0;
        mw_fl = 1'b0;

        if (freeze) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            xm_en = 1'b0;
            mw_fl = 1'b1;
        end else if (do_branch) begin
            // Squash the three wrong-path instructions. The PC keeps loading
            // so that the branch target is fetched next.
            fd_fl = 1'b1;
            dx_fl = 1'b1;
            xm_fl = 1'b1;
        end else if (release_ok && load_use) begin
            // Hold F and D for one cycle and send a bubble into X. When the
            // load moves on to M the match goes away, so the stall ends by itself.
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_fl = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State, wait counter, sticky error and performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == ST_ERROR) begin
                err_q <= 1'b1;
            end
            if (!pc_en) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (do_branch) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Reset forces the idle control pattern combinationally.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.pc_en_o     = pc_en || !reset_i;
        bus.fd_en_o     = fd_en || !reset_i;
        bus.dx_en_o     = dx_en || !reset_i;
        bus.xm_en_o     = xm_en || !reset_i;
        bus.fd_flush_o  = fd_fl && reset_i;
        bus.dx_flush_o  = dx_fl && reset_i;
        bus.xm_flush_o  = xm_fl && reset_i;
        bus.mw_flush_o  = mw_fl && reset_i;
        bus.fwd_a_o     = 2'b00;
        bus.fwd_b_o     = 2'b00;
        if (reset_i) begin
            bus.fwd_a_o = fwd_sel(bus.x_rs1_i, bus.m_regwrite_i, bus.m_rd_i,
                                  bus.w_regwrite_i, bus.w_rd_i);
            bus.fwd_b_o = fwd_sel(bus.x_rs2_i, bus.m_regwrite_i, bus.m_rd_i,
                                  bus.w_regwrite_i, bus.w_rd_i);
        end
        bus.state_o     = state;
        bus.stall_cnt_o = stall_cnt;
        bus.flush_cnt_o = flush_cnt;
        bus.err_o       = err_q;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturating performance counters.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: maximum data-memory wait cycles before the error condition.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port d_rs1_i/d_rs2_i, input, 5 each: source register addresses of the instruction in the FD register.
REQ-006 SHALL have port d_use_rs1_i/d_use_rs2_i, input, 1 each: the decode-stage instruction reads rs1/rs2.
REQ-007 SHALL have port x_rs1_i/x_rs2_i, input, 5 each: source register addresses in the DX register.
REQ-008 SHALL have port x_rd_i, input, 5, and x_memread_i, input, 1: destination register and load flag in DX.
REQ-009 SHALL have port m_rd_i, input, 5, and m_regwrite_i, input, 1: destination and write-enable in XM.
REQ-010 SHALL have port w_rd_i, input, 5, and w_regwrite_i, input, 1: destination and write-enable in MW.
REQ-011 SHALL have port m_branch_taken_i, input, 1: the branch resolved in M is taken.
REQ-012 SHALL have port dmem_req_i, input, 1, and dmem_ack_i, input, 1: data-memory access pending in M, and its completion.
REQ-013 SHALL have port pc_en_o, fd_en_o, dx_en_o, xm_en_o, input/output direction output, 1 each: stage-register load enables.
REQ-014 SHALL have port fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o, output, 1 each: bubble insertion into the corresponding register.
REQ-015 SHALL have port fwd_a_o/fwd_b_o, output, 2 each: ALU operand source (00 = register file, 10 = XM result, 01 = MW writeback).
REQ-016 SHALL have port state_o, output, 2: FSM state (00 RUN, 01 MEM_WAIT, 10 ERROR).
REQ-017 SHALL have port stall_cnt_o/flush_cnt_o, output, CNT_W each: saturating counts of stall cycles and branch flushes.
REQ-018 SHALL have port err_o, output, 1: sticky data-memory timeout flag.

Function
REQ-019 SHALL compute stage controls combinationally from state and inputs, with zero-cycle latency.
REQ-020 SHALL, in RUN, default all enables to 1 and all flushes to 0.
REQ-021 SHALL, in RUN, apply priority memory-wait > branch flush > load-use.
REQ-022 SHALL detect load-use when x_memread_i=1, x_rd_i!=0, and x_rd_i matches a used d_rs1_i/d_rs2_i.
REQ-023 SHALL, on load-use, drive pc_en_o=0, fd_en_o=0 and dx_flush_o=1 for exactly that cycle; the stall clears naturally the next cycle.
REQ-024 SHALL, on m_branch_taken_i=1 in RUN, drive fd_flush_o=dx_flush_o=xm_flush_o=1 with pc_en_o=1, so the target loads.
REQ-025 SHALL increment flush_cnt_o by 1 for each branch flush.
REQ-026 SHALL, when dmem_req_i=1 and dmem_ack_i=0 in RUN, drive pc/fd/dx/xm enables to 0 and mw_flush_o=1, and enter MEM_WAIT next edge.
REQ-027 SHALL, in MEM_WAIT, hold the same freeze outputs and increment a wait counter each cycle.
REQ-028 SHALL, in MEM_WAIT with dmem_ack_i=1, release the freeze in that same cycle, return to RUN, and clear the wait counter.
REQ-029 SHALL treat dmem_req_i=1 with dmem_ack_i=1 in RUN as a zero-wait access with no freeze.
REQ-030 SHALL, when the wait counter reaches ACK_TIMEOUT without ack, enter ERROR.
REQ-031 SHALL, in ERROR, hold all enables at 0 and set err_o=1 until reset; ack and branch inputs are ignored.
REQ-032 SHALL ignore m_branch_taken_i during a freeze; a branch still asserted on the ack cycle flushes in that cycle per REQ-024.
REQ-033 SHALL, during a freeze, suppress load-use stalls and let the freeze take precedence.
REQ-034 SHALL set fwd_a_o=10 when m_regwrite_i=1, m_rd_i!=0 and m_rd_i==x_rs1_i.
REQ-035 SHALL otherwise set fwd_a_o=01 when w_regwrite_i=1, w_rd_i!=0 and w_rd_i==x_rs1_i; else fwd_a_o=00.
REQ-036 SHALL compute fwd_b_o identically to fwd_a_o using x_rs2_i.
REQ-037 SHALL increment stall_cnt_o in every cycle with pc_en_o=0, including ERROR.
REQ-038 SHALL saturate both counters at all-ones without wrapping.

Reset
REQ-039 SHALL, while reset_i=0, asynchronously set state to RUN, clear both counters and the wait counter, and clear err_o.
REQ-040 SHALL, while reset_i=0, drive all enables to 1, all flushes to 0, and fwd outputs to 00.
REQ-041 SHALL abandon MEM_WAIT or ERROR immediately when reset is asserted mid-operation.

Verification
REQ-042 SHALL be verified with load-use: x_memread=1, x_rd=5, d_rs1=5, d_use_rs1=1 -> pc_en=0, fd_en=0, dx_flush=1 for one cycle, stall_cnt=1.
REQ-043 SHALL be verified with load-use against x0: x_rd=0 with a matching d_rs1 -> no stall.
REQ-044 SHALL be verified with branch: m_branch_taken=1 in RUN -> fd/dx/xm_flush=1, pc_en=1, flush_cnt=1.
REQ-045 SHALL be verified with memory wait: dmem_req=1, ack delayed 3 cycles -> freeze for 3 cycles with state_o=01, release on the ack cycle, stall_cnt=3.
REQ-046 SHALL be verified with timeout: dmem_req=1 and no ack -> ERROR after ACK_TIMEOUT cycles, err_o=1; asserting reset_i=0 returns RUN with counters 0.
REQ-047 SHALL be verified with forwarding: m_rd=w_rd=x_rs2=7 with both regwrite=1 -> fwd_b=10; m_regwrite=0 -> fwd_b=01.
